// File: rtl/mul_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arbiter_pkg
// Purpose  : Shared types and constants for the two-requester multiplier
//            arbiter: FSM state encoding, default operand width and the
//            product-width helper (2N+1).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mul_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int c_N_DEFAULT = 5;

    // Width of the unsigned product magnitude for N-bit signed operands.
    function automatic int res_width(input int n);
        return 2 * n + 1;
    endfunction

    localparam int c_RES_W_DEFAULT = res_width(c_N_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/mul_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arbiter_if
// Purpose  : Bundles the requester handshakes, the result bus and the link to
//            the external shared seq_mul.
// Modports : slave  - arbiter side (consumes requests / multiplier status)
//            master - environment side (requesters + seq_mul)
// Signals  : req0/req1, a0/b0/a1/b1, done0/done1, result, neg, busy,
//            mul_start, mul_a, mul_b, mul_ready, mul_result,
//            err (only when MUL_TIMEOUT_EN is defined)
// Revision : 1.0 - initial release
// ============================================================================
interface mul_share_arbiter_if
    import mul_share_arbiter_pkg::*;
#(
    parameter int N = c_N_DEFAULT
);
    localparam int c_RW = res_width(N);

    logic            req0;
    logic            req1;
    logic [N-1:0]    a0;
    logic [N-1:0]    b0;
    logic [N-1:0]    a1;
    logic [N-1:0]    b1;
    logic            done0;
    logic            done1;
    logic [c_RW-1:0] result;
    logic            neg;
    logic            busy;
    logic            mul_start;
    logic [N-1:0]    mul_a;
    logic [N-1:0]    mul_b;
    logic            mul_ready;
    logic [c_RW-1:0] mul_result;
`ifdef MUL_TIMEOUT_EN
    logic            err;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, mul_ready, mul_result,
        output done0, done1, result, neg, busy, mul_start, mul_a, mul_b, err
    );
    modport master (
        output req0, req1, a0, b0, a1, b1, mul_ready, mul_result,
        input  done0, done1, result, neg, busy, mul_start, mul_a, mul_b, err
    );
`else
    modport slave (
        input  req0, req1, a0, b0, a1, b1, mul_ready, mul_result,
        output done0, done1, result, neg, busy, mul_start, mul_a, mul_b
    );
    modport master (
        output req0, req1, a0, b0, a1, b1, mul_ready, mul_result,
        input  done0, done1, result, neg, busy, mul_start, mul_a, mul_b
    );
`endif

endinterface
`default_nettype wire

// File: rtl/mul_sign_abs.sv
`default_nettype none
// ============================================================================
// Module   : mul_sign_abs
// Purpose  : Splits an N-bit two's-complement operand into magnitude and sign.
//            The most-negative value -2^(N-1) maps to magnitude 2^(N-1),
//            which still fits in N unsigned bits.
// Ports    : val_i [N-1:0] in  - signed operand
//            mag_o [N-1:0] out - unsigned magnitude
//            sgn_o         out - 1 when operand is negative
// Revision : 1.0 - initial release
// ============================================================================
module mul_sign_abs #(
    parameter int N = 5
) (
    input  wire logic [N-1:0] val_i,
    output logic      [N-1:0] mag_o,
    output logic              sgn_o
);

    assign sgn_o = val_i[N-1];
    assign mag_o = sgn_o ? (N'(0) - val_i) : val_i;

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arbiter
// Purpose  : Round-robin arbiter letting two requesters share one external
//            sequential multiplier. Operand magnitudes go to the multiplier,
//            the product sign is tracked here and returned alongside the
//            unsigned magnitude.
// Ports    : clk  in  - rising-edge clock
//            rst  in  - asynchronous active-low reset
//            bus  slave modport of mul_share_arbiter_if
// Config   : MUL_TIMEOUT_EN - enables the WAIT watchdog (TIMEOUT cycles) and
//            the err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int N       = c_N_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mul_share_arbiter_if.slave bus
);

    localparam int c_RW = res_width(N);

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;        // 1: requester 1 wins a tie
    logic            gnt_q, gnt_d;        // grantee of the running operation
    logic            negn_q, negn_d;      // sign of the pending product
    logic [N-1:0]    mul_a_q, mul_a_d;
    logic [N-1:0]    mul_b_q, mul_b_d;
    logic [c_RW-1:0] result_q, result_d;
    logic            neg_q, neg_d;
    logic            rdy_q;

    logic            w_pick1;
    logic [N-1:0]    w_sel_a, w_sel_b;
    logic [N-1:0]    w_mag_a, w_mag_b;
    logic            w_sgn_a, w_sgn_b;
    logic            w_rdy_edge;

    // Requester 1 wins when alone or when the pointer favours it on a tie.
    assign w_pick1 = bus.req1 & (~bus.req0 | ptr_q);
    assign w_sel_a = w_pick1 ? bus.a1 : bus.a0;
    assign w_sel_b = w_pick1 ? bus.b1 : bus.b0;

    mul_sign_abs #(.N(N)) u_abs_a (
        .val_i (w_sel_a),
        .mag_o (w_mag_a),
        .sgn_o (w_sgn_a)
    );

    mul_sign_abs #(.N(N)) u_abs_b (
        .val_i (w_sel_b),
        .mag_o (w_mag_b),
        .sgn_o (w_sgn_b)
    );

    // Only a fresh rise completes WAIT; a ready still high from the previous
    // operation has rdy_q = 1 and produces no edge.
    assign w_rdy_edge = bus.mul_ready & ~rdy_q;

`ifdef MUL_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               w_timeout;

    assign w_timeout = (cnt_q == c_CNT_W'(TIMEOUT - 1));
    assign cnt_d     = (state_q == ST_WAIT) ? cnt_q + c_CNT_W'(1) : '0;
    assign bus.err   = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    // Watchdog absent; TIMEOUT is kept so both builds share one parameter list.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        negn_d   = negn_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        result_d = result_q;
        neg_d    = neg_q;
`ifdef MUL_TIMEOUT_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    state_d = ST_LAUNCH;
                    gnt_d   = w_pick1;
                    mul_a_d = w_mag_a;
                    mul_b_d = w_mag_b;
                    negn_d  = w_sgn_a ^ w_sgn_b;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_rdy_edge) begin
                    state_d  = ST_DONE;
                    result_d = bus.mul_result;
                    // A zero product is never reported as negative.
                    neg_d    = (bus.mul_result == '0) ? 1'b0 : negn_q;
                end
`ifdef MUL_TIMEOUT_EN
                else if (w_timeout) begin
                    state_d  = ST_DONE;
                    result_d = '0;
                    neg_d    = 1'b0;
                    err_d    = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = ~gnt_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            gnt_q    <= 1'b0;
            negn_q   <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            negn_q   <= negn_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            rdy_q    <= bus.mul_ready;
        end
    end

    assign bus.mul_start = (state_q == ST_LAUNCH);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done0     = (state_q == ST_DONE) & ~gnt_q;
    assign bus.done1     = (state_q == ST_DONE) &  gnt_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.result    = result_q;
    assign bus.neg       = neg_q;

endmodule
`default_nettype wire
